fetch_pc_unit: RTL and testbench

Parametrised program-counter / fetch-address generator for the RISC core. It holds the current fetch address and presents it to instruction memory over a valid/ready handshake. It advances by a configurable step on each accepted address and supports branch redirect, halt/resume and configurable overflow handling. It replaces the fixed 16-bit, step-1 combinational incrementor in the fetch path with a registered, stallable unit.

---
 rtl/fetch_pkg.sv | 21 ++
 rtl/fetch_pc_unit_step_adder.sv | 29 ++
 rtl/fetch_pc_unit.sv | 103 ++++++++++
 tb/tb_fetch_pc_unit.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and elaboration-time legality helpers for the fetch PC unit.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_e;

  function automatic bit width_ok(input int w);
    return w >= 2;
  endfunction

  // STEP must be a non-zero value that fits in WIDTH bits.
  function automatic bit step_ok(input longint step, input int w);
    if (step < 1) return 1'b0;
    if (w >= 63) return 1'b1;
    return step <= ((longint'(1) << w) - 1);
  endfunction

endpackage

// File: rtl/fetch_pc_unit_step_adder.sv
// Constant-increment ripple adder: half-adder cells where the STEP bit is 0,
// "add one" full-adder cells where it is 1.
module step_adder #(
  parameter int     WIDTH = 16,
  parameter longint STEP  = 1
) (
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam logic [WIDTH-1:0] B = WIDTH'(STEP);

  logic [WIDTH:0] c;
  assign c[0] = 1'b0;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    if (B[i]) begin : g_fa1
      assign sum[i]  = ~(a[i] ^ c[i]);
      assign c[i+1]  = a[i] | c[i];
    end else begin : g_ha
      assign sum[i]  = a[i] ^ c[i];
      assign c[i+1]  = a[i] & c[i];
    end
  end

  assign cout = c[WIDTH];

endmodule

// File: rtl/fetch_pc_unit.sv
// Registered, stallable fetch-address generator with redirect, halt/resume
// and selectable wrap-or-halt overflow behaviour.
module fetch_pc_unit
  import fetch_pkg::*;
#(
  parameter int               WIDTH        = 16,
  parameter longint           STEP         = 1,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter bit               WRAP_MODE    = 1'b1
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             ADDR_READY,
  input  logic             REDIRECT,
  input  logic [WIDTH-1:0] TARGET,
  input  logic             HALT_REQ,
  input  logic             RESUME,
  output logic [WIDTH-1:0] ADDR,
  output logic             ADDR_VALID,
  output logic             COUT,
  output logic             HALTED
);

  if (!width_ok(WIDTH)) begin : g_bad_width
    $error("fetch_pc_unit: WIDTH must be >= 2");
  end
  if (!step_ok(STEP, WIDTH)) begin : g_bad_step
    $error("fetch_pc_unit: STEP must be in 1 .. 2**WIDTH-1");
  end

  state_e           state_q, state_d;
  logic [WIDTH-1:0] addr_q, addr_d;
  logic             valid_q, valid_d;
  logic             cout_q, cout_d;
  logic             halted_q, halted_d;
  logic [WIDTH-1:0] sum;
  logic             carry;
  logic             hs;

  step_adder #(.WIDTH(WIDTH), .STEP(STEP)) u_step_adder (
    .a    (addr_q),
    .sum  (sum),
    .cout (carry)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cout_d  = 1'b0;
    hs      = valid_q & ADDR_READY;
    case (state_q)
      IDLE: begin
        if (REDIRECT) addr_d = TARGET;
        state_d = RUN;
      end
      RUN: begin
        if (REDIRECT) begin
          addr_d  = TARGET;
          state_d = HALT_REQ ? HALT : RUN;
        end else if (hs && carry && !WRAP_MODE) begin
          // Overflow without wrap: keep the last good address and stop.
          cout_d  = 1'b1;
          state_d = HALT;
        end else begin
          if (hs) begin
            addr_d = sum;
            cout_d = carry;
          end
          state_d = HALT_REQ ? HALT : RUN;
        end
      end
      HALT: begin
        if (REDIRECT) addr_d = TARGET;
        if (RESUME) state_d = RUN;
      end
      default: state_d = IDLE;
    endcase
    valid_d  = (state_d == RUN);
    halted_d = (state_d == HALT);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= IDLE;
      addr_q   <= RESET_VECTOR;
      valid_q  <= 1'b0;
      cout_q   <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      valid_q  <= valid_d;
      cout_q   <= cout_d;
      halted_q <= halted_d;
    end
  end

  assign ADDR       = addr_q;
  assign ADDR_VALID = valid_q;
  assign COUT       = cout_q;
  assign HALTED     = halted_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench: three fetch_pc_unit variants (step 1 wrap, step 4 wrap,
// step 1 halt-on-overflow) share one stimulus stream; a scoreboard checks them.
module tb_fetch_pc_unit;

  typedef struct packed {
    logic [1:0]  dut;
    logic [15:0] addr;
    logic        v;
    logic        c;
    logic        h;
  } exp_t;

  logic        CLK;
  logic        RST_N;
  logic        ADDR_READY;
  logic        REDIRECT;
  logic [15:0] TARGET;
  logic        HALT_REQ;
  logic        RESUME;
  logic [15:0] addr   [3];
  logic        valid  [3];
  logic        cout   [3];
  logic        halted [3];

  int   errors = 0;
  int   checks = 0;
  exp_t exp_q[$];
  string tag_q[$];

  fetch_pc_unit #(.WIDTH(16), .STEP(1), .RESET_VECTOR(16'h0100), .WRAP_MODE(1'b1)) u0 (
    .CLK(CLK), .RST_N(RST_N), .ADDR_READY(ADDR_READY), .REDIRECT(REDIRECT),
    .TARGET(TARGET), .HALT_REQ(HALT_REQ), .RESUME(RESUME),
    .ADDR(addr[0]), .ADDR_VALID(valid[0]), .COUT(cout[0]), .HALTED(halted[0]));

  fetch_pc_unit #(.WIDTH(16), .STEP(4), .RESET_VECTOR(16'h0000), .WRAP_MODE(1'b1)) u1 (
    .CLK(CLK), .RST_N(RST_N), .ADDR_READY(ADDR_READY), .REDIRECT(REDIRECT),
    .TARGET(TARGET), .HALT_REQ(HALT_REQ), .RESUME(RESUME),
    .ADDR(addr[1]), .ADDR_VALID(valid[1]), .COUT(cout[1]), .HALTED(halted[1]));

  fetch_pc_unit #(.WIDTH(16), .STEP(1), .RESET_VECTOR(16'h0000), .WRAP_MODE(1'b0)) u2 (
    .CLK(CLK), .RST_N(RST_N), .ADDR_READY(ADDR_READY), .REDIRECT(REDIRECT),
    .TARGET(TARGET), .HALT_REQ(HALT_REQ), .RESUME(RESUME),
    .ADDR(addr[2]), .ADDR_VALID(valid[2]), .COUT(cout[2]), .HALTED(halted[2]));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input exp_t e);
    logic [18:0] got, want;
    got  = {addr[e.dut], valid[e.dut], cout[e.dut], halted[e.dut]};
    want = {e.addr, e.v, e.c, e.h};
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s dut%0d: got addr=%h v=%b c=%b h=%b, want addr=%h v=%b c=%b h=%b",
             tag, e.dut, got[18:3], got[2], got[1], got[0],
             want[18:3], want[2], want[1], want[0]);
    end
  endtask

  task automatic expect_o(input int d, input string tag, input logic [15:0] a,
                          input logic v, input logic c, input logic h);
    exp_t e;
    e.dut = 2'(d); e.addr = a; e.v = v; e.c = c; e.h = h;
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic expect_all(input string tag, input logic [15:0] a,
                            input logic v, input logic c, input logic h);
    for (int d = 0; d < 3; d++) expect_o(d, tag, a, v, c, h);
  endtask

  task automatic check_now(input int d, input string tag, input logic [15:0] a,
                           input logic v, input logic c, input logic h);
    exp_t e;
    e.dut = 2'(d); e.addr = a; e.v = v; e.c = c; e.h = h;
    check(tag, e);
  endtask

  // Stimulus changes 1 unit after the rising edge; outputs are compared on the falling edge.
  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  always @(negedge CLK) begin
    while (exp_q.size() > 0) check(tag_q.pop_front(), exp_q.pop_front());
  end

  initial begin
    RST_N = 1'b0; ADDR_READY = 1'b1; REDIRECT = 1'b0; TARGET = '0;
    HALT_REQ = 1'b0; RESUME = 1'b0;

    repeat (2) cyc();
    expect_o(0, "reset_u0", 16'h0100, 0, 0, 0);
    expect_o(1, "reset_u1", 16'h0000, 0, 0, 0);
    expect_o(2, "reset_u2", 16'h0000, 0, 0, 0);

    cyc();
    RST_N = 1'b1;
    expect_o(0, "idle", 16'h0100, 0, 0, 0);
    cyc(); expect_o(0, "run0", 16'h0100, 1, 0, 0);
    cyc(); expect_o(0, "run1", 16'h0101, 1, 0, 0);
    cyc(); expect_o(0, "run2", 16'h0102, 1, 0, 0);

    // Stall at 0x0005
    REDIRECT = 1'b1; TARGET = 16'h0005;
    cyc(); REDIRECT = 1'b0; ADDR_READY = 1'b0;
    expect_all("redir5", 16'h0005, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(); expect_all("stall", 16'h0005, 1, 0, 0);
    end
    ADDR_READY = 1'b1;
    cyc(); ADDR_READY = 1'b0;
    expect_o(0, "unstall_u0", 16'h0006, 1, 0, 0);
    expect_o(1, "unstall_u1", 16'h0009, 1, 0, 0);
    expect_o(2, "unstall_u2", 16'h0006, 1, 0, 0);

    // Wrap with STEP=4
    REDIRECT = 1'b1; TARGET = 16'hFFFC;
    cyc(); REDIRECT = 1'b0;
    expect_all("redirFFFC", 16'hFFFC, 1, 0, 0);
    ADDR_READY = 1'b1;
    cyc(); ADDR_READY = 1'b0;
    expect_o(1, "wrap_u1", 16'h0000, 1, 1, 0);
    expect_o(0, "nowrap_u0", 16'hFFFD, 1, 0, 0);
    expect_o(2, "nowrap_u2", 16'hFFFD, 1, 0, 0);
    cyc(); expect_o(1, "wrap_cout_once", 16'h0000, 1, 0, 0);

    // Overflow: u2 halts, u0/u1 wrap
    REDIRECT = 1'b1; TARGET = 16'hFFFF;
    cyc(); REDIRECT = 1'b0;
    expect_all("redirFFFF", 16'hFFFF, 1, 0, 0);
    ADDR_READY = 1'b1;
    cyc(); ADDR_READY = 1'b0;
    expect_o(2, "ovf_halt_u2", 16'hFFFF, 0, 1, 1);
    expect_o(0, "ovf_wrap_u0", 16'h0000, 1, 1, 0);
    expect_o(1, "ovf_wrap_u1", 16'h0003, 1, 1, 0);
    cyc(); expect_o(2, "ovf_hold", 16'hFFFF, 0, 0, 1);
    RESUME = 1'b1;
    cyc(); RESUME = 1'b0;
    expect_o(2, "ovf_resume", 16'hFFFF, 1, 0, 0);
    expect_o(0, "resume_in_run", 16'h0000, 1, 0, 0);

    // Redirect beats halt_req and handshake
    REDIRECT = 1'b1; TARGET = 16'h0010;
    cyc(); expect_all("redir10", 16'h0010, 1, 0, 0);
    ADDR_READY = 1'b1; TARGET = 16'h2000; HALT_REQ = 1'b1;
    cyc(); HALT_REQ = 1'b0; TARGET = 16'h3000; RESUME = 1'b1;
    expect_all("prio_halt", 16'h2000, 0, 0, 1);
    cyc(); REDIRECT = 1'b0; RESUME = 1'b0;
    expect_all("redir_resume", 16'h3000, 1, 0, 0);

    // Halt request with handshake completes the increment
    HALT_REQ = 1'b1;
    cyc(); HALT_REQ = 1'b0; ADDR_READY = 1'b0;
    expect_o(0, "halt_inc_u0", 16'h3001, 0, 0, 1);
    expect_o(1, "halt_inc_u1", 16'h3004, 0, 0, 1);
    expect_o(2, "halt_inc_u2", 16'h3001, 0, 0, 1);
    HALT_REQ = 1'b1;
    cyc(); HALT_REQ = 1'b0;
    expect_o(0, "halt_ignore", 16'h3001, 0, 0, 1);
    RESUME = 1'b1;
    cyc(); RESUME = 1'b0;
    expect_o(0, "halt_resume", 16'h3001, 1, 0, 0);

    // Asynchronous reset mid-run
    REDIRECT = 1'b1; TARGET = 16'h1234;
    cyc(); REDIRECT = 1'b0;
    expect_all("redir1234", 16'h1234, 1, 0, 0);
    @(negedge CLK);
    #1;
    RST_N = 1'b0;
    #1;
    check_now(0, "async_rst_u0", 16'h0100, 0, 0, 0);
    check_now(1, "async_rst_u1", 16'h0000, 0, 0, 0);
    check_now(2, "async_rst_u2", 16'h0000, 0, 0, 0);

    cyc(); RST_N = 1'b1;
    repeat (2) @(negedge CLK);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
